// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo width in us,
// and a debounced near-target presence flag.
module ultrasonic_ranger #(
  parameter int US_DIV     = 50,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int PERIOD_US  = 65000,
  parameter int NEAR_US    = 1160,
  parameter int CONFIRM    = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        echo,
  output logic        trigger,
  output logic        detect,
  output logic [15:0] echo_us,
  output logic        meas_valid,
  output logic        timeout
);
  localparam int PSW = $clog2(US_DIV + 1);
  localparam int PCW = $clog2(PERIOD_US + 1);
  localparam int CFW = $clog2(CONFIRM + 1);

  typedef enum logic [2:0] {
    IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF
  } state_t;

  state_t state, state_n;

  logic [PSW-1:0] presc;
  logic [PCW-1:0] pcnt;
  logic [15:0]    scnt;
  logic [CFW-1:0] hcnt, mcnt, hcnt_n, mcnt_n;
  logic           echo_q, echo_s, echo_d;
  logic           tick, rise, fall;
  logic           wait_to, meas_to, done, hit, miss;

  assign tick = presc == PSW'(US_DIV - 1);
  assign rise = echo_s & ~echo_d;
  assign fall = ~echo_s & echo_d;

  assign hcnt_n = (hcnt == CFW'(CONFIRM)) ? hcnt
                                          : hcnt + CFW'(1);
  assign mcnt_n = (mcnt == CFW'(CONFIRM)) ? mcnt
                                          : mcnt + CFW'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // scnt is shared: trigger width, rise wait, echo width
  always_comb begin
    state_n = state;
    wait_to = 1'b0;
    meas_to = 1'b0;
    done    = 1'b0;
    hit     = 1'b0;
    miss    = 1'b0;
    if (!enable) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: state_n = TRIG;
        TRIG: begin
          if (tick && scnt == 16'(TRIG_US - 1))
            state_n = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            state_n = MEASURE;
          end else if (tick &&
                       scnt == 16'(TIMEOUT_US - 1)) begin
            state_n = HOLDOFF;
            wait_to = 1'b1;
            miss    = 1'b1;
          end
        end
        MEASURE: begin
          if (fall) begin
            state_n = HOLDOFF;
            done    = 1'b1;
            hit     = scnt < 16'(NEAR_US);
            miss    = !(scnt < 16'(NEAR_US));
          end else if (tick &&
                       scnt == 16'(TIMEOUT_US - 1)) begin
            state_n = HOLDOFF;
            meas_to = 1'b1;
            miss    = 1'b1;
          end
        end
        HOLDOFF: begin
          if (tick && pcnt >= PCW'(PERIOD_US - 1))
            state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      echo_q     <= 1'b0;
      echo_s     <= 1'b0;
      echo_d     <= 1'b0;
      presc      <= '0;
      pcnt       <= '0;
      scnt       <= '0;
      hcnt       <= '0;
      mcnt       <= '0;
      trigger    <= 1'b0;
      detect     <= 1'b0;
      echo_us    <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      echo_q     <= echo;
      echo_s     <= echo_q;
      echo_d     <= echo_s;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      if (!enable) begin
        presc   <= '0;
        pcnt    <= '0;
        scnt    <= '0;
        hcnt    <= '0;
        mcnt    <= '0;
        trigger <= 1'b0;
        detect  <= 1'b0;
      end else begin
        trigger <= state_n == TRIG;
        if (state == IDLE || tick) presc <= '0;
        else                       presc <= presc + PSW'(1);
        if (state == IDLE)
          pcnt <= '0;
        else if (tick && pcnt != PCW'(PERIOD_US))
          pcnt <= pcnt + PCW'(1);
        if (state_n != state)
          scnt <= '0;
        else if (tick && (state == TRIG ||
                          state == WAIT_RISE ||
                          (state == MEASURE && echo_s)))
          scnt <= scnt + 16'd1;
        if (wait_to) timeout <= 1'b1;
        if (done) begin
          echo_us    <= scnt;
          meas_valid <= 1'b1;
        end
        if (meas_to) begin
          echo_us    <= 16'(TIMEOUT_US);
          meas_valid <= 1'b1;
          timeout    <= 1'b1;
        end
        unique case (1'b1)
          hit: begin
            hcnt <= hcnt_n;
            mcnt <= '0;
            if (hcnt_n == CFW'(CONFIRM)) detect <= 1'b1;
          end
          miss: begin
            mcnt <= mcnt_n;
            hcnt <= '0;
            if (mcnt_n == CFW'(CONFIRM)) detect <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with scaled-down timing
// and an event-level model checked on every clock.
`timescale 1ns/1ps
module tb_ultrasonic_ranger;
  localparam int DIV  = 4;
  localparam int TRG  = 3;
  localparam int TMO  = 40;
  localparam int PER  = 100;
  localparam int NEAR = 20;
  localparam int CONF = 3;
  localparam int TW   = TRG * DIV;
  localparam int PCLK = PER * DIV + 1;
  localparam int D    = 5;
  localparam int HITW = 6;
  localparam int MISW = 30;

  logic        clock = 1'b0;
  logic        reset_n, enable, echo;
  logic        trigger, detect, meas_valid, timeout;
  logic [15:0] echo_us;

  ultrasonic_ranger #(
    .US_DIV(DIV), .TRIG_US(TRG), .TIMEOUT_US(TMO),
    .PERIOD_US(PER), .NEAR_US(NEAR), .CONFIRM(CONF)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .echo(echo), .trigger(trigger), .detect(detect),
    .echo_us(echo_us), .meas_valid(meas_valid),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vec  = 0;
  int errs = 0;
  bit chk_en = 1'b1;

  // model: expected events keyed by clock number
  bit exp_trig[int];
  bit exp_mv[int];
  bit exp_to[int];
  int lo_at[int];
  int hi_at[int];
  bit det_at[int];
  int cur_lo = 0;
  int cur_hi = 0;
  bit cur_det = 1'b0;
  bit hist[$];
  bit m_det = 1'b0;
  int t0;

  typedef enum {K_ECHO, K_NONE, K_STUCK} kind_t;

  task automatic chk(input bit ok, input string name,
                     input int act, input int exp);
    vec++;
    if (!ok) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d",
               name, cyc, act, exp);
    end
  endtask

  // detect follows the last CONF results when they all agree
  function automatic void record(input int c, input bit h);
    int nh;
    hist.push_back(h);
    if (hist.size() > CONF) void'(hist.pop_front());
    if (hist.size() == CONF) begin
      nh = 0;
      foreach (hist[i]) nh += int'(hist[i]);
      if (nh == CONF) m_det = 1'b1;
      else if (nh == 0) m_det = 1'b0;
    end
    det_at[c] = m_det;
  endfunction

  function automatic void mark_trig(input int s);
    for (int i = 0; i < TW; i++) exp_trig[s + i] = 1'b1;
  endfunction

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic run_period(input kind_t k, input int w);
    int tf, ke, kf, c;
    tf = t0 + TW;
    ke = tf + D * DIV;
    mark_trig(t0);
    case (k)
      K_ECHO: begin
        kf = ke + w * DIV;
        c  = kf + 3;
        exp_mv[c] = 1'b1;
        lo_at[c]  = w - 1;
        hi_at[c]  = w + 1;
        record(c, w < NEAR);
        goto(ke);
        echo = 1'b1;
        goto(kf);
        echo = 1'b0;
      end
      K_NONE: begin
        c = tf + TMO * DIV;
        exp_to[c] = 1'b1;
        record(c, 1'b0);
      end
      K_STUCK: begin
        c = tf + (D + TMO) * DIV;
        exp_mv[c] = 1'b1;
        exp_to[c] = 1'b1;
        lo_at[c]  = TMO;
        hi_at[c]  = TMO;
        record(c, 1'b0);
        goto(ke);
        echo = 1'b1;
        goto(t0 + 80 * DIV);
        echo = 1'b0;
      end
      default: ;
    endcase
    goto(t0 + 90 * DIV);
    t0 += PCLK;
  endtask

  task automatic run_abort();
    int tf, ke;
    tf = t0 + TW;
    ke = tf + D * DIV;
    mark_trig(t0);
    goto(ke);
    echo = 1'b1;
    goto(ke + 10);
    hist.delete();
    m_det = 1'b0;
    det_at[ke + 11] = 1'b0;
    enable = 1'b0;
    goto(ke + 15);
    echo = 1'b0;
    goto(ke + 20);
    chk(detect == 1'b0, "abort_detect", detect, 0);
    chk(trigger == 1'b0, "abort_trigger", trigger, 0);
    enable = 1'b1;
    t0 = ke + 21;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      if (exp_mv.exists(cyc)) begin
        cur_lo = lo_at[cyc];
        cur_hi = hi_at[cyc];
      end
      if (det_at.exists(cyc)) cur_det = det_at[cyc];
      chk(trigger == exp_trig.exists(cyc), "trigger",
          trigger, int'(exp_trig.exists(cyc)));
      chk(meas_valid == exp_mv.exists(cyc), "meas_valid",
          meas_valid, int'(exp_mv.exists(cyc)));
      chk(timeout == exp_to.exists(cyc), "timeout",
          timeout, int'(exp_to.exists(cyc)));
      chk(detect == cur_det, "detect", detect, cur_det);
      chk(int'(echo_us) >= cur_lo && int'(echo_us) <= cur_hi,
          "echo_us", int'(echo_us), cur_lo);
    end
  end

  int rises[$];
  int widths[$];
  int to_gaps[$];
  int last_rise = 0;
  int last_fall = 0;
  bit tp = 1'b0;

  always @(negedge clock) begin
    if (trigger && !tp) begin
      rises.push_back(cyc);
      last_rise = cyc;
    end
    if (!trigger && tp) begin
      widths.push_back(cyc - last_rise);
      last_fall = cyc;
    end
    if (timeout) to_gaps.push_back(cyc - last_fall);
    tp = trigger;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    echo    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk(trigger == 1'b0, "rst_trigger", trigger, 0);
    chk(detect == 1'b0, "rst_detect", detect, 0);
    chk(echo_us == 16'd0, "rst_echo_us", echo_us, 0);
    chk(meas_valid == 1'b0, "rst_meas_valid", meas_valid, 0);
    chk(timeout == 1'b0, "rst_timeout", timeout, 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    t0 = cyc + 1;

    run_period(K_ECHO, HITW);
    chk(echo_us >= 16'd5 && echo_us <= 16'd7,
        "p1_echo_us", echo_us, 6);
    run_period(K_ECHO, HITW);
    chk(detect == 1'b0, "two_hits_detect", detect, 0);
    run_period(K_ECHO, HITW);
    chk(detect == 1'b1, "three_hits_detect", detect, 1);

    run_period(K_ECHO, MISW);
    run_period(K_ECHO, MISW);
    run_period(K_ECHO, HITW);
    run_period(K_ECHO, MISW);
    run_period(K_ECHO, MISW);
    chk(detect == 1'b1, "two_miss_hold", detect, 1);
    run_period(K_ECHO, MISW);
    chk(detect == 1'b0, "three_miss_clear", detect, 0);
    chk(echo_us >= 16'd29 && echo_us <= 16'd31,
        "miss_echo_us", echo_us, 30);

    for (int i = 0; i < 3; i++) run_period(K_ECHO, HITW);
    chk(detect == 1'b1, "rehit_detect", detect, 1);
    run_period(K_NONE, 0);
    chk(echo_us >= 16'd5 && echo_us <= 16'd7,
        "timeout_keeps_echo_us", echo_us, 6);
    run_period(K_NONE, 0);
    chk(detect == 1'b1, "two_timeouts_hold", detect, 1);
    run_period(K_NONE, 0);
    chk(detect == 1'b0, "three_timeouts_clear", detect, 0);

    run_period(K_STUCK, 0);
    chk(echo_us == 16'd40, "stuck_echo_us", echo_us, 40);

    for (int i = 0; i < 3; i++) run_period(K_ECHO, HITW);
    chk(detect == 1'b1, "pre_abort_detect", detect, 1);
    run_abort();
    run_period(K_ECHO, HITW);
    chk(detect == 1'b0, "post_abort_detect", detect, 0);

    mark_trig(t0);
    goto(t0 + 2);
    chk(trigger == 1'b1, "pre_reset_trigger", trigger, 1);
    chk_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk(trigger == 1'b0, "async_rst_trigger", trigger, 0);
    chk(echo_us == 16'd0, "async_rst_echo_us", echo_us, 0);
    chk(detect == 1'b0, "async_rst_detect", detect, 0);

    if (widths.size() >= 1)
      chk(widths[0] == 12, "trig_width", widths[0], 12);
    else
      chk(1'b0, "trig_width_seen", widths.size(), 1);
    if (rises.size() >= 2)
      chk(rises[1] - rises[0] == 401, "trig_period",
          rises[1] - rises[0], 401);
    else
      chk(1'b0, "trig_rises_seen", rises.size(), 2);
    if (to_gaps.size() >= 1)
      chk(to_gaps[0] == 160, "timeout_delay", to_gaps[0], 160);
    else
      chk(1'b0, "timeout_seen", to_gaps.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end
endmodule
